// File: rtl/pattern_count_engine.sv
// pattern_count_engine
//   Scans a message in data memory for a 5-bit pattern and writes back three
//   counts. The first count is matches that lie inside one byte. The second is
//   the number of bytes holding at least one such match. The third is matches
//   anywhere in the concatenated bit string, where byte 0 is the most
//   significant and windows may straddle byte boundaries.
//
//   Ports
//     CLK        in   rising-edge clock
//     RESET_N    in   asynchronous active-low reset
//     START      in   begins a run when sampled high in IDLE or FINISH
//     DONE       out  high from end of run until the next accepted START
//     BUSY       out  high while a run is in progress (LOAD_PAT..WR_S)
//     MEM_ADDR   out  data-memory byte address
//     MEM_WE     out  write strobe, one cycle per result byte
//     MEM_WDATA  out  write data
//     MEM_RDATA  in   read data, valid the cycle after MEM_ADDR is sampled
module pattern_count_engine #(
  parameter int unsigned STR_BASE  = 128,
  parameter int unsigned NUM_BYTES = 32,
  parameter int unsigned PAT_ADDR  = 160,
  parameter int unsigned RES_BASE  = 192
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  output logic       DONE,
  output logic       BUSY,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_WE,
  output logic [7:0] MEM_WDATA,
  input  logic [7:0] MEM_RDATA
);

  localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_PAT, S_SCAN, S_WR_B, S_WR_O, S_WR_S, S_FINISH
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [4:0]       pat;
  logic [3:0]       prev_lo;
  logic [7:0]       ctb, cto, cts;
  logic             accept;
  logic [2:0]       w_in;
  logic [3:0]       w_cross;

  // Matches of pt in the four windows that fit entirely inside byte d.
  function automatic logic [2:0] count_in(input logic [7:0] d, input logic [4:0] pt);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < 4; k++)
      if (d[k +: 5] == pt) n = n + 3'd1;
    return n;
  endfunction

  // Matches of pt in the eight windows whose lowest bit lies in the current
  // byte; the upper bits may reach up to four bits into the previous byte.
  function automatic logic [3:0] count_cross(input logic [11:0] x, input logic [4:0] pt);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++)
      if (x[k +: 5] == pt) n = n + 4'd1;
    return n;
  endfunction

  assign accept  = START && (state == S_IDLE || state == S_FINISH);
  assign w_in    = count_in(MEM_RDATA, pat);
  // The first byte has no predecessor, so only its in-byte windows count.
  assign w_cross = (idx == IDX_W'(1)) ? {1'b0, w_in}
                                      : count_cross({prev_lo, MEM_RDATA}, pat);

  // Next state and combinational outputs
  always_comb begin
    state_nx  = state;
    DONE      = 1'b0;
    BUSY      = 1'b0;
    MEM_ADDR  = 8'd0;
    MEM_WE    = 1'b0;
    MEM_WDATA = 8'd0;
    case (state)
      S_IDLE: begin
        if (START) state_nx = S_LOAD_PAT;
      end
      S_LOAD_PAT: begin
        BUSY     = 1'b1;
        MEM_ADDR = 8'(PAT_ADDR);
        state_nx = S_SCAN;
      end
      S_SCAN: begin
        BUSY = 1'b1;
        // The final SCAN cycle only consumes the last byte; no new read.
        if (idx < LAST) MEM_ADDR = 8'(STR_BASE) + 8'(idx);
        if (idx == LAST) state_nx = S_WR_B;
      end
      S_WR_B: begin
        BUSY      = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = 8'(RES_BASE);
        MEM_WDATA = ctb;
        state_nx  = S_WR_O;
      end
      S_WR_O: begin
        BUSY      = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = 8'(RES_BASE + 1);
        MEM_WDATA = cto;
        state_nx  = S_WR_S;
      end
      S_WR_S: begin
        BUSY      = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = 8'(RES_BASE + 2);
        MEM_WDATA = cts;
        state_nx  = S_FINISH;
      end
      S_FINISH: begin
        DONE = 1'b1;
        if (START) state_nx = S_LOAD_PAT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, index, pattern and counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      pat     <= '0;
      prev_lo <= '0;
      ctb     <= '0;
      cto     <= '0;
      cts     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx     <= '0;
        prev_lo <= '0;
        ctb     <= '0;
        cto     <= '0;
        cts     <= '0;
      end else if (state == S_SCAN) begin
        if (idx == '0) begin
          pat <= MEM_RDATA[7:3];
        end else begin
          // MEM_RDATA holds byte idx-1 here.
          ctb     <= ctb + {5'd0, w_in};
          cto     <= cto + {7'd0, (w_in != 3'd0)};
          cts     <= cts + {4'd0, w_cross};
          prev_lo <= MEM_RDATA[3:0];
        end
        if (idx != LAST) idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
